hvac_sequencer: RTL



---
 rtl/hvac_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/hvac_sequencer.sv
// Heat/cool plant sequencer: hysteresis start, minimum run, lockout between runs; actuators follow the state register (1 cycle after a qualifying decision).
// Optional emergency stop input EStop is compiled in with HVAC_ESTOP_EN.
module hvac_sequencer #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned MIN_RUN  = 60,
    parameter int unsigned LOCKOUT  = 30,
    parameter int unsigned HYST     = 1,
    parameter logic [7:0]  MODE_SEL = 8'd3
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] Selector,
    input  logic [3:0] TargetTens,
    input  logic [3:0] TargetOnes,
    input  logic [3:0] RoomTens,
    input  logic [3:0] RoomOnes,
    input  logic       RoomValid,
`ifdef HVAC_ESTOP_EN
    input  logic       EStop,
`endif
    output logic       CoolOn,
    output logic       HeatOn,
    output logic [1:0] State,
    output logic       Fault
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [7:0] MIN_RUN_C = 8'(MIN_RUN);
    localparam logic [7:0] LOCK_C    = 8'(LOCKOUT);
    localparam logic [7:0] HYST_C    = 8'(HYST);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_COOL = 2'b01,
        ST_HEAT = 2'b10,
        ST_LOCK = 2'b11
    } state_t;

    function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
        return {3'b000, tens} * 7'd10 + {3'b000, ones};
    endfunction

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   presc;
    logic [7:0]      cnt;
    logic [6:0]      room;
    logic [6:0]      target;
    logic            have_room;
    logic            fault;

    logic            active;
    logic            tick;
    logic            room_ok;
    logic            target_ok;
    logic            estop;
    logic [7:0]      room8;
    logic [7:0]      target8;
    logic [7:0]      room_hi;
    logic [7:0]      target_hi;

    assign active    = (Selector == MODE_SEL);
    assign tick      = (presc == PRESC_MAX);
    assign room_ok   = (RoomTens <= 4'd9) && (RoomOnes <= 4'd9);
    assign target_ok = (TargetTens <= 4'd9) && (TargetOnes <= 4'd9);
    assign room8     = {1'b0, room};
    assign target8   = {1'b0, target};
    assign room_hi   = room8 + HYST_C;
    assign target_hi = target8 + HYST_C;

`ifdef HVAC_ESTOP_EN
    assign estop = EStop;
`else
    assign estop = 1'b0;
`endif

    // Decisions use only registered room/target/counter, so a same-cycle update lands next edge.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (active && have_room) begin
                    if (room8 >= target_hi) begin
                        state_nxt = ST_COOL;
                    end else if (room_hi <= target8) begin
                        state_nxt = ST_HEAT;
                    end
                end
            end
            ST_COOL: begin
                if ((cnt >= MIN_RUN_C) && ((room8 <= target8) || !active)) begin
                    state_nxt = ST_LOCK;
                end
            end
            ST_HEAT: begin
                if ((cnt >= MIN_RUN_C) && ((room8 >= target8) || !active)) begin
                    state_nxt = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (cnt >= LOCK_C) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (estop) begin
            state_nxt = (state == ST_IDLE) ? ST_IDLE : ST_LOCK;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= ST_IDLE;
            presc     <= '0;
            cnt       <= 8'd0;
            room      <= 7'd0;
            target    <= 7'd0;
            have_room <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state <= state_nxt;
            presc <= tick ? '0 : presc + 1'b1;

            if (state_nxt != state) begin
                cnt <= 8'd0;
            end else if (tick && (cnt != 8'hFF)) begin
                cnt <= cnt + 8'd1;
            end

            if (active) begin
                if (target_ok) begin
                    target <= bcd_to_bin(TargetTens, TargetOnes);
                end else begin
                    fault <= 1'b1;
                end
            end

            if (RoomValid) begin
                if (room_ok) begin
                    room      <= bcd_to_bin(RoomTens, RoomOnes);
                    have_room <= 1'b1;
                end else begin
                    fault <= 1'b1;
                end
            end
        end
    end

    assign State  = state;
    assign CoolOn = (state == ST_COOL);
    assign HeatOn = (state == ST_HEAT);
    assign Fault  = fault;

endmodule
